// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-master RAM bus arbiter: FSM state type,
// master index constants and the round-robin pick used at arbitration time.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package ram_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam logic M_IFETCH = 1'b0;
   localparam logic M_LSU    = 1'b1;

   // On a tie the master that was not served last wins.
   function automatic logic rr_pick(input logic cs0, input logic cs1, input logic last);
      logic pick;
      if (cs0 && cs1)
         pick = ~last;
      else if (cs1)
         pick = M_LSU;
      else
         pick = M_IFETCH;
      return pick;
   endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one word-wide RAM slave between the instruction
// fetch port (M0) and the load/store port (M1); one transaction per grant.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W = `ADDR_SIZE,
   parameter int DATA_W = `WORD_SIZE
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [ADDR_W-1:0] M0_addr,
   input  logic              M0_cs,
   input  logic              M0_we,
   input  logic [DATA_W-1:0] M0_wdata,
   output logic [DATA_W-1:0] M0_rdata,
   output logic              M0_ack,
   input  logic [ADDR_W-1:0] M1_addr,
   input  logic              M1_cs,
   input  logic              M1_we,
   input  logic [DATA_W-1:0] M1_wdata,
   output logic [DATA_W-1:0] M1_rdata,
   output logic              M1_ack,
   output logic [ADDR_W-1:0] S_addr,
   output logic              S_cs,
   output logic              S_we,
   output logic [DATA_W-1:0] S_wdata,
   input  logic [DATA_W-1:0] S_rdata,
   input  logic              S_ack
);

   arb_state_t        r_state;
   logic              r_grant;
   logic              r_last_grant;
   logic              r_issued;

   logic              w_busy;
   logic              w_g_cs;
   logic              w_g_we;
   logic [ADDR_W-1:0] w_g_addr;
   logic [DATA_W-1:0] w_g_wdata;
   logic              w_done;
   logic              w_deliver;

   assign w_busy = (r_state == BUSY);

   always_comb begin
      w_g_cs    = M0_cs;
      w_g_we    = M0_we;
      w_g_addr  = M0_addr;
      w_g_wdata = M0_wdata;
      if (r_grant == M_LSU) begin
         w_g_cs    = M1_cs;
         w_g_we    = M1_we;
         w_g_addr  = M1_addr;
         w_g_wdata = M1_wdata;
      end
   end

   // The request is presented only until it has been issued, which keeps S_cs
   // low in the ack cycle and guarantees an idle gap between slave requests.
   assign S_cs    = w_busy & w_g_cs & ~r_issued;
   assign S_we    = w_busy ? w_g_we    : 1'b0;
   assign S_addr  = w_busy ? w_g_addr  : '0;
   assign S_wdata = w_busy ? w_g_wdata : '0;

   // An ack for a master that dropped cs after issue is swallowed here.
   assign w_done    = w_busy & r_issued & S_ack;
   assign w_deliver = w_done & w_g_cs & ~Rst;

   assign M0_ack   = w_deliver & (r_grant == M_IFETCH);
   assign M1_ack   = w_deliver & (r_grant == M_LSU);
   assign M0_rdata = M0_ack ? S_rdata : '0;
   assign M1_rdata = M1_ack ? S_rdata : '0;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state      <= IDLE;
         r_grant      <= M_IFETCH;
         r_last_grant <= M_LSU;
         r_issued     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_issued <= 1'b0;
               if (M0_cs || M1_cs) begin
                  r_grant <= rr_pick(M0_cs, M1_cs, r_last_grant);
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (w_done) begin
                  r_state      <= IDLE;
                  r_last_grant <= r_grant;
                  r_issued     <= 1'b0;
               end else if (!r_issued && !w_g_cs) begin
                  r_state <= IDLE;
               end else if (S_cs) begin
                  r_issued <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized two-master traffic
// checked against a word-level memory model and a fairness rule.
`timescale 1ns/1ps

module tb_ram_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          Clk = 1'b0;
   logic          Rst;
   logic [AW-1:0] M0_addr, M1_addr, S_addr;
   logic          M0_cs, M0_we, M1_cs, M1_we, S_cs, S_we;
   logic [DW-1:0] M0_wdata, M1_wdata, M0_rdata, M1_rdata, S_wdata, S_rdata;
   logic          M0_ack, M1_ack, S_ack;

   logic          pl_en;
   logic [7:0]    pl_idx;
   logic [DW-1:0] pl_data;
   logic [DW-1:0] ram [0:255];
   logic [DW-1:0] model_mem [0:255];

   int nerr = 0;
   int nchecks = 0;

   always #5 Clk = ~Clk;

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .Clk(Clk), .Rst(Rst),
      .M0_addr(M0_addr), .M0_cs(M0_cs), .M0_we(M0_we), .M0_wdata(M0_wdata),
      .M0_rdata(M0_rdata), .M0_ack(M0_ack),
      .M1_addr(M1_addr), .M1_cs(M1_cs), .M1_we(M1_we), .M1_wdata(M1_wdata),
      .M1_rdata(M1_rdata), .M1_ack(M1_ack),
      .S_addr(S_addr), .S_cs(S_cs), .S_we(S_we), .S_wdata(S_wdata),
      .S_rdata(S_rdata), .S_ack(S_ack)
   );

   // Slave RAM: registered ack one cycle after S_cs, cleared by Rst.
   always @(posedge Clk) begin
      if (Rst) begin
         S_ack <= 1'b0;
         for (int i = 0; i < 256; i++) ram[i] <= '0;
      end else begin
         S_ack <= S_cs;
         if (S_cs) begin
            if (S_we) ram[S_addr[9:2]] <= S_wdata;
            S_rdata <= ram[S_addr[9:2]];
         end
      end
      if (pl_en) ram[pl_idx] <= pl_data;
   end

   task automatic idle_inputs();
      M0_addr = '0; M0_cs = 1'b0; M0_we = 1'b0; M0_wdata = '0;
      M1_addr = '0; M1_cs = 1'b0; M1_we = 1'b0; M1_wdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      Rst = 1'b1;
      repeat (2) @(negedge Clk);
      Rst = 1'b0;
      @(negedge Clk);
   endtask

   task automatic preload(input logic [7:0] idx, input logic [DW-1:0] data);
      pl_idx = idx; pl_data = data; pl_en = 1'b1;
      @(negedge Clk);
      pl_en = 1'b0;
   endtask

   // One bounded transaction; the other master must stay silent throughout.
   task automatic xact(input int m, input logic [AW-1:0] a, input logic we,
                       input logic [DW-1:0] wd, output logic [DW-1:0] rd, output int cyc);
      cyc = -1;
      rd  = '0;
      if (m == 0) begin
         M0_addr = a; M0_we = we; M0_wdata = wd; M0_cs = 1'b1;
      end else begin
         M1_addr = a; M1_we = we; M1_wdata = wd; M1_cs = 1'b1;
      end
      for (int k = 1; k <= 12 && cyc < 0; k++) begin
         @(negedge Clk);
         nchecks++;
         if (m == 0) begin
            if (M0_ack) begin cyc = k; rd = M0_rdata; end
            if (M1_ack !== 1'b0 || M1_rdata !== '0) begin
               nerr++;
               $display("FAIL other_quiet m1 ack=%b rdata=%h expected ack=0 rdata=0", M1_ack, M1_rdata);
            end
         end else begin
            if (M1_ack) begin cyc = k; rd = M1_rdata; end
            if (M0_ack !== 1'b0 || M0_rdata !== '0) begin
               nerr++;
               $display("FAIL other_quiet m0 ack=%b rdata=%h expected ack=0 rdata=0", M0_ack, M0_rdata);
            end
         end
      end
      if (m == 0) M0_cs = 1'b0; else M1_cs = 1'b0;
      nchecks++;
      if (cyc < 0) begin
         nerr++;
         $display("FAIL xact_timeout m=%0d got no ack expected ack within 12 cycles", m);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      Rst = 1'b1;
      M0_cs = 1'b1; M1_cs = 1'b1; M0_addr = 32'h44; M1_addr = 32'h48;
      repeat (3) @(negedge Clk);
      nchecks++;
      if ({S_cs, S_we, S_addr, S_wdata, M0_ack, M1_ack, M0_rdata, M1_rdata} !== '0) begin
         nerr++;
         $display("FAIL reset_held_outputs S_cs=%b S_addr=%h M0_ack=%b M1_ack=%b expected all 0",
                  S_cs, S_addr, M0_ack, M1_ack);
      end
      idle_inputs();
      Rst = 1'b0;
      @(negedge Clk);
      nchecks++;
      if ({S_cs, S_we, S_addr, S_wdata, M0_ack, M1_ack, M0_rdata, M1_rdata} !== '0) begin
         nerr++;
         $display("FAIL reset_release_outputs S_cs=%b S_addr=%h expected all 0", S_cs, S_addr);
      end
   endtask

   task automatic test_single_read();
      preload(8'h04, 32'hDEADBEEF);
      M0_addr = 32'h10; M0_we = 1'b0; M0_cs = 1'b1;
      @(negedge Clk);
      nchecks++;
      if (S_cs !== 1'b1 || S_addr !== 32'h10 || S_we !== 1'b0 || M0_ack !== 1'b0) begin
         nerr++;
         $display("FAIL single_issue S_cs=%b S_addr=%h M0_ack=%b expected S_cs=1 S_addr=10 M0_ack=0",
                  S_cs, S_addr, M0_ack);
      end
      @(negedge Clk);
      nchecks++;
      if (M0_ack !== 1'b1 || M0_rdata !== 32'hDEADBEEF || M1_ack !== 1'b0 || S_cs !== 1'b0) begin
         nerr++;
         $display("FAIL single_ack M0_ack=%b M0_rdata=%h M1_ack=%b S_cs=%b expected 1 deadbeef 0 0",
                  M0_ack, M0_rdata, M1_ack, S_cs);
      end
      M0_cs = 1'b0;
      @(negedge Clk);
      nchecks++;
      if (M0_ack !== 1'b0 || M0_rdata !== '0 || S_cs !== 1'b0) begin
         nerr++;
         $display("FAIL single_after M0_ack=%b M0_rdata=%h S_cs=%b expected 0 0 0", M0_ack, M0_rdata, S_cs);
      end
   endtask

   task automatic test_tie();
      int t0, t1, cyc;
      logic [DW-1:0] rd;
      do_reset();
      t0 = -1; t1 = -1;
      M0_addr = 32'h0;  M0_we = 1'b0; M0_cs = 1'b1;
      M1_addr = 32'h20; M1_we = 1'b1; M1_wdata = 32'h12345678; M1_cs = 1'b1;
      for (int k = 1; k <= 12 && (t0 < 0 || t1 < 0); k++) begin
         @(negedge Clk);
         if (M0_ack && t0 < 0) begin t0 = k; M0_cs = 1'b0; end
         if (M1_ack && t1 < 0) begin t1 = k; M1_cs = 1'b0; end
      end
      M0_cs = 1'b0; M1_cs = 1'b0;
      nchecks++;
      if (t0 != 2 || t1 != 5) begin
         nerr++;
         $display("FAIL tie_order M0 ack cycle=%0d M1 ack cycle=%0d expected 2 and 5", t0, t1);
      end
      xact(0, 32'h20, 1'b0, '0, rd, cyc);
      nchecks++;
      if (rd !== 32'h12345678) begin
         nerr++;
         $display("FAIL tie_readback got=%h expected=12345678", rd);
      end
   endtask

   task automatic test_back_to_back();
      int n, last, cnt0, cnt1;
      do_reset();
      n = 0; last = 0; cnt0 = 0; cnt1 = 0;
      M0_addr = 32'h0; M0_we = 1'b0; M0_cs = 1'b1;
      M1_addr = 32'h4; M1_we = 1'b0; M1_cs = 1'b1;
      for (int k = 1; k <= 40 && n < 8; k++) begin
         @(negedge Clk);
         if (M0_ack || M1_ack) begin
            nchecks++;
            if (S_cs !== 1'b0 || (M0_ack && M1_ack) || M1_ack !== 1'(n % 2)) begin
               nerr++;
               $display("FAIL b2b_grant n=%0d M0_ack=%b M1_ack=%b S_cs=%b expected master %0d with S_cs=0",
                        n, M0_ack, M1_ack, S_cs, n % 2);
            end
            nchecks++;
            if ((n == 0 && k != 2) || (n > 0 && k - last != 3)) begin
               nerr++;
               $display("FAIL b2b_spacing n=%0d cycle=%0d previous=%0d expected spacing 3", n, k, last);
            end
            if (M0_ack) cnt0++;
            if (M1_ack) cnt1++;
            last = k;
            n++;
         end
      end
      idle_inputs();
      nchecks++;
      if (cnt0 != 4 || cnt1 != 4) begin
         nerr++;
         $display("FAIL b2b_counts M0=%0d M1=%0d expected 4 and 4", cnt0, cnt1);
      end
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_abort();
      do_reset();
      M1_addr = 32'h44; M1_we = 1'b0; M1_cs = 1'b1;
      @(negedge Clk);
      nchecks++;
      if (S_cs !== 1'b1 || S_addr !== 32'h44) begin
         nerr++;
         $display("FAIL abort_grant S_cs=%b S_addr=%h expected 1 and 44", S_cs, S_addr);
      end
      M1_cs = 1'b0;
      M0_addr = 32'h48; M0_we = 1'b0; M0_cs = 1'b1;
      #1;
      nchecks++;
      if (S_cs !== 1'b0) begin
         nerr++;
         $display("FAIL abort_drop S_cs=%b expected 0", S_cs);
      end
      @(negedge Clk);
      nchecks++;
      if (S_cs !== 1'b0 || S_ack !== 1'b0 || M0_ack !== 1'b0 || M1_ack !== 1'b0) begin
         nerr++;
         $display("FAIL abort_idle S_cs=%b S_ack=%b M0_ack=%b M1_ack=%b expected all 0",
                  S_cs, S_ack, M0_ack, M1_ack);
      end
      @(negedge Clk);
      nchecks++;
      if (S_cs !== 1'b1 || S_addr !== 32'h48 || M1_ack !== 1'b0) begin
         nerr++;
         $display("FAIL abort_next_grant S_cs=%b S_addr=%h expected 1 and 48", S_cs, S_addr);
      end
      @(negedge Clk);
      nchecks++;
      if (M0_ack !== 1'b1 || M1_ack !== 1'b0) begin
         nerr++;
         $display("FAIL abort_m0_ack M0_ack=%b M1_ack=%b expected 1 and 0", M0_ack, M1_ack);
      end
      M0_cs = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_reset_mid();
      int cyc;
      logic [DW-1:0] rd;
      M0_addr = 32'h10; M0_we = 1'b0; M0_cs = 1'b1;
      @(negedge Clk);
      nchecks++;
      if (S_cs !== 1'b1) begin
         nerr++;
         $display("FAIL rstmid_issue S_cs=%b expected 1", S_cs);
      end
      Rst = 1'b1;
      @(negedge Clk);
      nchecks++;
      if ({S_cs, S_we, S_addr, S_wdata, M0_ack, M1_ack, M0_rdata, M1_rdata} !== '0) begin
         nerr++;
         $display("FAIL rstmid_outputs S_cs=%b S_addr=%h M0_ack=%b expected all 0", S_cs, S_addr, M0_ack);
      end
      Rst = 1'b0;
      M0_cs = 1'b0;
      xact(1, 32'h80, 1'b1, 32'h5A5A0F0F, rd, cyc);
      nchecks++;
      if (cyc != 2) begin
         nerr++;
         $display("FAIL rstmid_fresh_latency got=%0d expected=2", cyc);
      end
      xact(1, 32'h80, 1'b0, '0, rd, cyc);
      nchecks++;
      if (rd !== 32'h5A5A0F0F) begin
         nerr++;
         $display("FAIL rstmid_readback got=%h expected=5a5a0f0f", rd);
      end
   endtask

   task automatic test_write_then_read();
      int cyc;
      logic [DW-1:0] rd;
      @(negedge Clk);
      xact(1, 32'h40, 1'b1, 32'hA5A5A5A5, rd, cyc);
      @(negedge Clk);
      xact(0, 32'h40, 1'b0, '0, rd, cyc);
      nchecks++;
      if (rd !== 32'hA5A5A5A5) begin
         nerr++;
         $display("FAIL wr_rd_data got=%h expected=a5a5a5a5", rd);
      end
   endtask

   task automatic test_random();
      logic          act [2];
      logic          wr [2];
      logic [AW-1:0] ad [2];
      logic [DW-1:0] dt [2];
      logic [DW-1:0] rdv [2];
      logic          ack [2];
      int            gap [2];
      int            waitc [2];
      int            skip [2];
      int            served [2];
      for (int i = 0; i < 256; i++) model_mem[i] = '0;
      for (int m = 0; m < 2; m++) begin
         act[m] = 1'b0; wr[m] = 1'b0; ad[m] = '0; dt[m] = '0;
         gap[m] = m; waitc[m] = 0; skip[m] = 0; served[m] = 0;
      end
      do_reset();
      for (int c = 0; c < 600; c++) begin
         @(negedge Clk);
         ack[0] = M0_ack; ack[1] = M1_ack;
         rdv[0] = M0_rdata; rdv[1] = M1_rdata;
         if (ack[0] || ack[1]) begin
            nchecks++;
            if (S_cs !== 1'b0 || (ack[0] && ack[1])) begin
               nerr++;
               $display("FAIL rnd_ack_cycle S_cs=%b M0_ack=%b M1_ack=%b expected S_cs=0 single ack",
                        S_cs, ack[0], ack[1]);
            end
         end
         for (int m = 0; m < 2; m++) begin
            if (ack[m]) begin
               nchecks++;
               if (!act[m]) begin
                  nerr++;
                  $display("FAIL rnd_spurious_ack m=%0d got ack=1 expected 0", m);
               end else if (wr[m]) begin
                  model_mem[ad[m][9:2]] = dt[m];
               end else if (rdv[m] !== model_mem[ad[m][9:2]]) begin
                  nerr++;
                  $display("FAIL rnd_read m=%0d addr=%h got=%h expected=%h",
                           m, ad[m], rdv[m], model_mem[ad[m][9:2]]);
               end
               if (act[1-m]) begin
                  skip[1-m]++;
                  nchecks++;
                  if (skip[1-m] > 1) begin
                     nerr++;
                     $display("FAIL rnd_starve m=%0d skipped=%0d expected at most 1", 1 - m, skip[1-m]);
                  end
               end
               skip[m] = 0;
               act[m] = 1'b0;
               served[m]++;
               gap[m] = $urandom_range(0, 2);
            end else begin
               nchecks++;
               if (rdv[m] !== '0) begin
                  nerr++;
                  $display("FAIL rnd_rdata_idle m=%0d got=%h expected=0", m, rdv[m]);
               end
               if (act[m]) begin
                  waitc[m]++;
                  if (waitc[m] > 8) begin
                     nerr++;
                     nchecks++;
                     $display("FAIL rnd_timeout m=%0d waited=%0d expected ack within 8", m, waitc[m]);
                     act[m] = 1'b0;
                     gap[m] = 1;
                  end
               end
            end
            if (!act[m]) begin
               if (gap[m] == 0) begin
                  act[m] = 1'b1;
                  waitc[m] = 0;
                  ad[m] = 32'h200 + (32'($urandom_range(0, 15)) << 2);
                  wr[m] = 1'($urandom_range(0, 1));
                  dt[m] = $urandom;
               end else begin
                  gap[m]--;
               end
            end
         end
         M0_cs = act[0]; M0_addr = ad[0]; M0_we = wr[0]; M0_wdata = dt[0];
         M1_cs = act[1]; M1_addr = ad[1]; M1_we = wr[1]; M1_wdata = dt[1];
      end
      idle_inputs();
      repeat (4) @(negedge Clk);
      nchecks++;
      if (served[0] < 20 || served[1] < 20) begin
         nerr++;
         $display("FAIL rnd_progress M0=%0d M1=%0d expected at least 20 each", served[0], served[1]);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      pl_en = 1'b0; pl_idx = '0; pl_data = '0;
      Rst = 1'b1;
      idle_inputs();
      @(negedge Clk);
      test_reset();
      test_single_read();
      test_tie();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_write_then_read();
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule
